ram32x4_scan_reader: RTL and testbench
======================================

Name: ram32x4_scan_reader

Overview:
- Sequential read-out engine for the 32-word x 4-bit synchronous RAM (ram32x4) used on the board.
- Steps through every address, issues each read, and captures the 4-bit word one cycle later.
- Holds each address/data pair stable on registered outputs for a programmable dwell time, so the HEX decoders can show it.
- Supports single-pass and continuous-loop scanning, plus pause and abort.

Parameters:
- HOLD_CYCLES, 50000000, dwell time per word in clock cycles (>=1); 1 s at 50 MHz.
- ADDR_W, 5, RAM address width; depth is 2**ADDR_W.
- DATA_W, 4, RAM data width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  level-sampled request; begins a scan from address 0 when IDLE or DONE.
- loop  input  1  1 = wrap to address 0 after the last word; 0 = stop in DONE. Sampled when leaving HOLD at the last address.
- pause  input  1  1 freezes the dwell counter in HOLD; no effect in other states.
- stop  input  1  synchronous abort to IDLE from any state; has priority over start.
- ram_addr  output  ADDR_W  address to RAM; registered.
- ram_wren  output  1  write enable to RAM; constant 0.
- ram_q  input  DATA_W  RAM read data; valid the cycle after ram_addr changes.
- disp_addr  output  ADDR_W  address of the displayed word.
- disp_data  output  DATA_W  displayed word.
- valid  output  1  one-cycle pulse when disp_addr/disp_data update.
- busy  output  1  1 in ISSUE, WAIT and HOLD.
- done  output  1  1 in DONE.

Behaviour:
- Reset: state=IDLE; ram_addr, disp_addr, disp_data and dwell counter = 0; valid, busy and done = 0. Reset mid-scan abandons the scan immediately.
- States: IDLE, ISSUE, WAIT, HOLD, DONE.
- IDLE: start=1 and stop=0 -> ram_addr<=0, go to ISSUE.
- ISSUE: ram_addr is stable for one cycle -> go to WAIT.
- WAIT: ram_q is valid at the end of this cycle. At that edge: disp_data<=ram_q, disp_addr<=ram_addr, valid<=1 for exactly the next cycle, counter<=HOLD_CYCLES-1, go to HOLD.
- HOLD:
  - pause=1: counter holds.
  - pause=0 and counter!=0: counter decrements.
  - pause=0 and counter==0, ram_addr!=2**ADDR_W-1: ram_addr<=ram_addr+1, go to ISSUE.
  - pause=0 and counter==0, last address, loop=1: ram_addr<=0 (wrap), go to ISSUE.
  - pause=0 and counter==0, last address, loop=0: go to DONE.
- DONE: disp_* hold the last word. start=1 -> ram_addr<=0, go to ISSUE (restart).
- stop=1 in any state -> IDLE at the next edge; disp_* keep their values; ram_addr<=0.
- start held high in HOLD or ISSUE is ignored, with no restart.
- Latency: start edge to first valid pulse = 3 cycles (IDLE->ISSUE->WAIT->valid).
- Word period: HOLD_CYCLES+2 cycles per word, so first-to-next valid spacing = HOLD_CYCLES+2.
- Dwell counter width: $clog2(HOLD_CYCLES+1), minimum 1. HOLD_CYCLES=1 gives a single HOLD cycle.
- Address arithmetic is modulo 2**ADDR_W; no other wrap source.

Optional Feature:
- Macro: RAM_SCAN_CHECKSUM_EN.
- Defined:
  - Adds output checksum [7:0], cleared to 0 on reset, on start-from-IDLE/DONE and on loop wrap.
  - checksum<=checksum+ram_q (modulo 256) at each WAIT capture edge.
  - Adds output checksum_valid: 1 in DONE, 0 elsewhere.
- Undefined: no checksum ports or logic; port list is as above.

Test Plan:
- RAM model preloaded with mem[i]=i[3:0], HOLD_CYCLES=4, loop=0, start pulse -> valid pulses every 6 cycles, 32 in total.
  - First valid 3 cycles after start, with disp_addr=0, disp_data=0.
  - Word 17 shows disp_data=1.
  - Ends in DONE with disp_addr=31, disp_data=15, busy=0.
- Same setup, loop=1 -> after address 31, next valid shows disp_addr=0; done never asserts over 70 words.
- pause=1 for 10 cycles in HOLD of address 5 -> next valid (address 6) delayed by exactly 10 cycles; disp_addr stays 5 meanwhile.
- stop=1 during WAIT of address 9 -> IDLE next edge, busy=0, no valid pulse for address 9, disp_addr holds 8.
  - A later start rescans from address 0.
- resetn low mid-HOLD -> all outputs 0 asynchronously; ram_wren 0 throughout every test.
- With RAM_SCAN_CHECKSUM_EN, mem[i]=i[3:0] -> checksum=8'd240 (2x sum 0..15) with checksum_valid=1 in DONE; restart clears it to 0.

Source files
------------

// File: rtl/ram32x4_scan_reader.sv
// ram32x4_scan_reader: walks every address of a 32x4 synchronous RAM, captures
// each word one cycle after issuing its address, and holds the address/data
// pair on registered outputs for HOLD_CYCLES clocks so it can be displayed.
// Optional build macro RAM_SCAN_CHECKSUM_EN adds a running 8-bit checksum of
// every captured word plus a checksum_valid flag that is high in DONE.
module ram32x4_scan_reader #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              loop,
  input  logic              pause,
  input  logic              stop,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              valid,
  output logic              busy,
  output logic              done
`ifdef RAM_SCAN_CHECKSUM_EN
  ,
  output logic [7:0]        checksum,
  output logic              checksum_valid
`endif
);

  localparam int CNT_RAW = $clog2(HOLD_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_disp_addr;
  logic [DATA_W-1:0]   r_disp_data;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;
  logic [CNT_W-1:0]    r_cnt;

`ifdef RAM_SCAN_CHECKSUM_EN
  logic [7:0]          r_csum;
  logic                r_csum_vld;

  // Modulo-256 accumulation of one captured word.
  function automatic logic [7:0] f_csum_add(input logic [7:0] acc,
                                            input logic [DATA_W-1:0] d);
    return acc + 8'(d);
  endfunction

  assign checksum       = r_csum;
  assign checksum_valid = r_csum_vld;
`endif

  assign ram_addr  = r_addr;
  assign ram_wren  = 1'b0;
  assign disp_addr = r_disp_addr;
  assign disp_data = r_disp_data;
  assign valid     = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

  // Scan FSM: state, RAM address, dwell counter and all registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_disp_addr <= '0;
      r_disp_data <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cnt       <= '0;
`ifdef RAM_SCAN_CHECKSUM_EN
      r_csum      <= '0;
      r_csum_vld  <= 1'b0;
`endif
    end else begin
      // valid is a single-cycle strobe; only the WAIT capture raises it.
      r_valid <= 1'b0;
      if (stop) begin
        // Abort wins over everything; the displayed word is left untouched.
        r_state <= S_IDLE;
        r_addr  <= '0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
`ifdef RAM_SCAN_CHECKSUM_EN
        r_csum_vld <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_addr  <= '0;
              r_state <= S_ISSUE;
              r_busy  <= 1'b1;
`ifdef RAM_SCAN_CHECKSUM_EN
              r_csum  <= '0;
`endif
            end
          end
          S_ISSUE: begin
            // Address has been stable for a cycle; RAM latches it this edge.
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            r_disp_data <= ram_q;
            r_disp_addr <= r_addr;
            r_valid     <= 1'b1;
            r_cnt       <= CNT_LOAD;
            r_state     <= S_HOLD;
`ifdef RAM_SCAN_CHECKSUM_EN
            r_csum      <= f_csum_add(r_csum, ram_q);
`endif
          end
          S_HOLD: begin
            if (!pause) begin
              if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
              end else if (r_addr != ADDR_LAST) begin
                r_addr  <= r_addr + 1'b1;
                r_state <= S_ISSUE;
              end else if (loop) begin
                r_addr  <= '0;
                r_state <= S_ISSUE;
`ifdef RAM_SCAN_CHECKSUM_EN
                r_csum  <= '0;
`endif
              end else begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
`ifdef RAM_SCAN_CHECKSUM_EN
                r_csum_vld <= 1'b1;
`endif
              end
            end
          end
          S_DONE: begin
            if (start) begin
              r_addr  <= '0;
              r_state <= S_ISSUE;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
`ifdef RAM_SCAN_CHECKSUM_EN
              r_csum     <= '0;
              r_csum_vld <= 1'b0;
`endif
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram32x4_scan_reader.sv
// Testbench for ram32x4_scan_reader with HOLD_CYCLES=4 and a behavioural
// synchronous RAM preloaded with mem[i] = i[3:0].
module tb_ram32x4_scan_reader;

  localparam int HOLD = 4;
  localparam int PER  = HOLD + 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0, loop = 1'b0, pause = 1'b0, stop = 1'b0;
  logic [4:0] ram_addr;
  logic       ram_wren;
  logic [3:0] ram_q = 4'd0;
  logic [4:0] disp_addr;
  logic [3:0] disp_data;
  logic       valid, busy, done;
`ifdef RAM_SCAN_CHECKSUM_EN
  logic [7:0] checksum;
  logic       checksum_valid;
`endif

  ram32x4_scan_reader #(.HOLD_CYCLES(HOLD), .ADDR_W(5), .DATA_W(4)) dut (
    .clk(clk), .resetn(resetn), .start(start), .loop(loop), .pause(pause),
    .stop(stop), .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_q(ram_q),
    .disp_addr(disp_addr), .disp_data(disp_data), .valid(valid),
    .busy(busy), .done(done)
`ifdef RAM_SCAN_CHECKSUM_EN
    , .checksum(checksum), .checksum_valid(checksum_valid)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous RAM model
  logic [3:0] mem [32];
  always @(posedge clk) ram_q <= mem[ram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [4:0] a; logic [3:0] d; } ev_t;
  ev_t evq[$];
  always @(negedge clk) if (valid === 1'b1) evq.push_back('{cyc, disp_addr, disp_data});

  bit wren_bad = 1'b0;
  always @(negedge clk) if (ram_wren !== 1'b0) wren_bad = 1'b1;

  typedef struct { int idx; logic [4:0] a; logic [3:0] d; } vec_t;
  vec_t tbl [6];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    start = 0; loop = 0; pause = 0; stop = 0;
    @(negedge clk);
    resetn = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
    @(negedge clk);
  endtask

  task automatic pulse_start(output int c);
    start = 1;
    c = cyc;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_valid_addr(input logic [4:0] a, input int maxc, output int c, output bit ok);
    ok = 0; c = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (valid === 1'b1 && disp_addr === a) begin
        ok = 1; c = cyc;
      end
    end
  endtask

  task automatic wait_done(input int maxc, output bit ok);
    ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1;
    end
  endtask

  initial begin
    int  c0, c5, c6, n9;
    bit  ok, done_seen;

    tbl[0] = '{0,  5'd0,  4'd0};
    tbl[1] = '{1,  5'd1,  4'd1};
    tbl[2] = '{15, 5'd15, 4'd15};
    tbl[3] = '{16, 5'd16, 4'd0};
    tbl[4] = '{17, 5'd17, 4'd1};
    tbl[5] = '{31, 5'd31, 4'd15};
    for (int i = 0; i < 32; i++) mem[i] = 4'(i);

    // Reset state (resetn low from time 0)
    #12;
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_disp_addr", 32'(disp_addr), 0);
    chk("rst_disp_data", 32'(disp_data), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);

    // Single pass scan
    do_reset();
    evq.delete();
    pulse_start(c0);
    wait_done(32 * PER + 20, ok);
    chk("pass_done_reached", 32'(ok), 1);
    chk("pass_count", 32'(evq.size()), 32);
    chk("pass_latency", 32'(evq[0].cyc - c0), 3);
    foreach (tbl[i]) begin
      chk($sformatf("pass_addr_w%0d", tbl[i].idx), 32'(evq[tbl[i].idx].a), 32'(tbl[i].a));
      chk($sformatf("pass_data_w%0d", tbl[i].idx), 32'(evq[tbl[i].idx].d), 32'(tbl[i].d));
    end
    for (int i = 1; i < 32; i++)
      chk($sformatf("pass_spacing_%0d", i), 32'(evq[i].cyc - evq[i-1].cyc), PER);
    chk("done_flag", 32'(done), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_disp_addr", 32'(disp_addr), 31);
    chk("done_disp_data", 32'(disp_data), 15);
    chk("done_valid", 32'(valid), 0);
`ifdef RAM_SCAN_CHECKSUM_EN
    chk("csum_done", 32'(checksum), 240);
    chk("csum_valid_done", 32'(checksum_valid), 1);
`endif
    // Restart from DONE
    evq.delete();
    pulse_start(c0);
    chk("restart_busy", 32'(busy), 1);
    chk("restart_done", 32'(done), 0);
`ifdef RAM_SCAN_CHECKSUM_EN
    chk("csum_cleared", 32'(checksum), 0);
    chk("csum_valid_cleared", 32'(checksum_valid), 0);
`endif
    wait_valid_addr(5'd0, 10, c5, ok);
    chk("restart_first_valid", 32'(ok), 1);
    chk("restart_latency", 32'(c5 - c0), 3);

    // Continuous loop
    do_reset();
    evq.delete();
    loop = 1;
    done_seen = 0;
    pulse_start(c0);
    for (int i = 0; i < 70 * PER + 20 && evq.size() < 70; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen = 1;
    end
    chk("loop_count_reached", 32'(evq.size() >= 70), 1);
    chk("loop_no_done", 32'(done_seen), 0);
    chk("loop_w31_addr", 32'(evq[31].a), 31);
    chk("loop_wrap_addr", 32'(evq[32].a), 0);
    chk("loop_wrap_data", 32'(evq[32].d), 0);
    chk("loop_wrap_spacing", 32'(evq[32].cyc - evq[31].cyc), PER);
    chk("loop_w69_addr", 32'(evq[69].a), 5);
    stop = 1;
    @(negedge clk);
    stop = 0;
    chk("loop_stop_busy", 32'(busy), 0);
    loop = 0;

    // Pause in HOLD of address 5
    do_reset();
    pulse_start(c0);
    wait_valid_addr(5'd5, 6 * PER + 10, c5, ok);
    chk("pause_a5_seen", 32'(ok), 1);
    pause = 1;
    repeat (10) @(negedge clk);
    chk("pause_disp_hold", 32'(disp_addr), 5);
    chk("pause_busy", 32'(busy), 1);
    pause = 0;
    wait_valid_addr(5'd6, 30, c6, ok);
    chk("pause_a6_seen", 32'(ok), 1);
    chk("pause_delay", 32'(c6 - c5), PER + 10);

    // Stop during WAIT of address 9
    do_reset();
    pulse_start(c0);
    wait_valid_addr(5'd8, 9 * PER + 10, c5, ok);
    chk("stop_a8_seen", 32'(ok), 1);
    repeat (5) @(negedge clk);
    chk("stop_pre_busy", 32'(busy), 1);
    evq.delete();
    stop = 1;
    @(negedge clk);
    stop = 0;
    chk("stop_busy", 32'(busy), 0);
    chk("stop_valid", 32'(valid), 0);
    chk("stop_disp_addr", 32'(disp_addr), 8);
    chk("stop_disp_data", 32'(disp_data), 8);
    chk("stop_ram_addr", 32'(ram_addr), 0);
    repeat (8) @(negedge clk);
    n9 = 0;
    foreach (evq[i]) if (evq[i].a == 5'd9) n9++;
    chk("stop_no_a9", 32'(n9), 0);
    chk("stop_idle_busy", 32'(busy), 0);
    evq.delete();
    pulse_start(c0);
    wait_valid_addr(5'd0, 10, c5, ok);
    chk("stop_rescan_a0", 32'(ok), 1);
    chk("stop_rescan_latency", 32'(c5 - c0), 3);

    // Asynchronous reset mid-HOLD
    wait_valid_addr(5'd3, 4 * PER + 10, c5, ok);
    chk("areset_a3_seen", 32'(ok), 1);
    #2 resetn = 0;
    #1;
    chk("areset_ram_addr", 32'(ram_addr), 0);
    chk("areset_disp_addr", 32'(disp_addr), 0);
    chk("areset_disp_data", 32'(disp_data), 0);
    chk("areset_valid", 32'(valid), 0);
    chk("areset_busy", 32'(busy), 0);
    chk("areset_done", 32'(done), 0);
    @(negedge clk);
    resetn = 1;
    repeat (3) @(negedge clk);
    chk("areset_stays_idle", 32'(busy), 0);

    chk("ram_wren_low", 32'(wren_bad), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
